// File: rtl/score_count_multi_if.sv
// score_count_multi_if: event inputs and score/display outputs of the counter.
// master drives events (judge side); slave is the counter.
interface score_count_multi_if #(
  parameter int DIGITS = 3
);
  logic                  incrementInPos;
  logic                  incrementInNeg;
  logic [1:0]            incrementAmount;
  logic [4*DIGITS-1:0]   score;
  logic [7*DIGITS-1:0]   leds;
  logic                  incrementOutPos;
  logic                  incrementOutNeg;
  logic                  isZero;

  modport master (
    output incrementInPos, incrementInNeg, incrementAmount,
    input  score, leds, incrementOutPos, incrementOutNeg, isZero
  );

  modport slave (
    input  incrementInPos, incrementInNeg, incrementAmount,
    output score, leds, incrementOutPos, incrementOutNeg, isZero
  );
endinterface

// File: rtl/score_count_multi.sv
// score_count_multi: multi-digit BCD score counter, +/-1..3 steps, clamp or wrap,
// carry/borrow pulses, active-low abcdefg per digit. Ports: Clock, Reset, bus (slave).
module score_count_multi #(
  parameter int DIGITS      = 3,
  parameter int WRAP        = 0,
  parameter int EDGE_DETECT = 1,
  parameter int BLANK_LZ    = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  score_count_multi_if.slave bus
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

  logic [W-1:0] score_q, score_d;
  logic [W-1:0] sum_w, dif_w;
  logic         prevPos_q, prevNeg_q;
  logic         outPos_q, outPos_d;
  logic         outNeg_q, outNeg_d;
  logic         posEv, negEv;
  logic         carry, borrow;
  logic         step;
  logic [4:0]   t;
  logic [1:0]   c;
  logic [1:0]   b;
  logic [3:0]   d;
  logic         lz;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Held-through-reset inputs look like "already high" so they need a fresh rise.
  assign posEv = bus.incrementInPos
               & ((EDGE_DETECT == 0) | ~prevPos_q);
  assign negEv = bus.incrementInNeg
               & ((EDGE_DETECT == 0) | ~prevNeg_q);
  assign step  = |bus.incrementAmount;

  // Decimal ripple add; digit 0 takes the step, higher digits the carry.
  always_comb begin
    sum_w = '0;
    t     = '0;
    c     = bus.incrementAmount;
    for (int k = 0; k < DIGITS; k++) begin
      t = {1'b0, score_q[4*k +: 4]} + {3'b0, c};
      if (t > 5'd9) begin
        sum_w[4*k +: 4] = t[3:0] - 4'd10;
        c = 2'd1;
      end else begin
        sum_w[4*k +: 4] = t[3:0];
        c = 2'd0;
      end
    end
    carry = c[0];
  end

  // Decimal ripple subtract; a final borrow leaves diff + 10^DIGITS.
  always_comb begin
    dif_w = '0;
    d     = '0;
    b     = bus.incrementAmount;
    for (int k = 0; k < DIGITS; k++) begin
      d = score_q[4*k +: 4];
      if (d < {2'b0, b}) begin
        dif_w[4*k +: 4] = d + 4'd10 - {2'b0, b};
        b = 2'd1;
      end else begin
        dif_w[4*k +: 4] = d - {2'b0, b};
        b = 2'd0;
      end
    end
    borrow = b[0];
  end

  always_comb begin
    score_d  = score_q;
    outPos_d = 1'b0;
    outNeg_d = 1'b0;
    if (posEv & ~negEv & step) begin
      outPos_d = carry;
      score_d  = (carry && WRAP == 0) ? NINES : sum_w;
    end else if (negEv & ~posEv & step) begin
      outNeg_d = borrow;
      score_d  = (borrow && WRAP == 0) ? '0 : dif_w;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      score_q   <= '0;
      prevPos_q <= 1'b1;
      prevNeg_q <= 1'b1;
      outPos_q  <= 1'b0;
      outNeg_q  <= 1'b0;
    end else begin
      score_q   <= score_d;
      prevPos_q <= bus.incrementInPos;
      prevNeg_q <= bus.incrementInNeg;
      outPos_q  <= outPos_d;
      outNeg_q  <= outNeg_d;
    end
  end

  // lz stays high while this digit and all above it are zero.
  always_comb begin
    bus.leds = '1;
    lz       = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz = lz & (score_q[4*k +: 4] == 4'd0);
      if (BLANK_LZ != 0 && k > 0 && lz)
        bus.leds[7*k +: 7] = 7'b1111111;
      else
        bus.leds[7*k +: 7] = seg7(score_q[4*k +: 4]);
    end
  end

  assign bus.score           = score_q;
  assign bus.isZero          = (score_q == '0);
  assign bus.incrementOutPos = outPos_q;
  assign bus.incrementOutNeg = outNeg_q;

endmodule
